// File: rtl/battle_turn_ctrl_if.sv
// Signal bundle between battle_turn_ctrl and its neighbours: the keypad and
// collision inputs, the battle engine's status inputs, and the attack-request
// outputs to the engine. master = turn controller, slave = engine/keypad side.
interface battle_turn_ctrl_if;
    localparam int unsigned CODE_W = 2;
    localparam int unsigned AMMO_W = 5;

    // keypad decode / collision detection
    logic              collision_detected;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;

    // battle engine status
    logic [AMMO_W-1:0] player_remained_sword;
    logic [AMMO_W-1:0] player_remained_baseballbat;
    logic [AMMO_W-1:0] enemy_remained_sword;
    logic [AMMO_W-1:0] enemy_remained_baseballbat;
    logic              player_win;
    logic              enemy_win;

    // attack requests and status
    logic [CODE_W-1:0] player_choice;
    logic              player_turn;
    logic [CODE_W-1:0] enemy_choice;
    logic              attacker_turn;
    logic              battle_active;
    logic              turn_owner;
    logic              key_reject;

    modport master (
        input  collision_detected,
        input  key_valid,
        input  key_code,
        input  player_remained_sword,
        input  player_remained_baseballbat,
        input  enemy_remained_sword,
        input  enemy_remained_baseballbat,
        input  player_win,
        input  enemy_win,
        output player_choice,
        output player_turn,
        output enemy_choice,
        output attacker_turn,
        output battle_active,
        output turn_owner,
        output key_reject
    );

    modport slave (
        output collision_detected,
        output key_valid,
        output key_code,
        output player_remained_sword,
        output player_remained_baseballbat,
        output enemy_remained_sword,
        output enemy_remained_baseballbat,
        output player_win,
        output enemy_win,
        input  player_choice,
        input  player_turn,
        input  enemy_choice,
        input  attacker_turn,
        input  battle_active,
        input  turn_owner,
        input  key_reject
    );
endinterface

// File: rtl/battle_turn_ctrl.sv
// Turn sequencer for the battle engine. Alternates player and enemy attack
// requests, refuses player keys for exhausted weapons, picks enemy moves from
// a free-running LFSR and stops once the engine reports a winner.
// Optional build macro TURN_TIMEOUT_EN: forces a punch when the player idles
// for TIMEOUT_CYCLES in WAIT_PLAYER; without it the player may wait forever.
module battle_turn_ctrl #(
    parameter int unsigned THINK_CYCLES    = 16,
    parameter int unsigned COOLDOWN_CYCLES = 4,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input logic               clk,
    input logic               rst_n,
    battle_turn_ctrl_if.master bus
);

    localparam int unsigned CODE_W  = 2;
    localparam int unsigned MAX_CT  = (COOLDOWN_CYCLES > THINK_CYCLES) ? COOLDOWN_CYCLES : THINK_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_CT > TIMEOUT_CYCLES) ? MAX_CT : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CODE_W-1:0] CODE_PUNCH = 2'b00;
    localparam logic [CODE_W-1:0] CODE_KICK  = 2'b01;
    localparam logic [CODE_W-1:0] CODE_SWORD = 2'b10;
    localparam logic [CODE_W-1:0] CODE_BAT   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PLAYER,
        PLAYER_STRIKE,
        COOLDOWN_P,
        ENEMY_THINK,
        ENEMY_STRIKE,
        COOLDOWN_E,
        DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [7:0]        lfsr;

    logic [CODE_W-1:0] player_choice_q, player_choice_nxt;
    logic [CODE_W-1:0] enemy_choice_q, enemy_choice_nxt;
    logic              player_turn_q, player_turn_nxt;
    logic              attacker_turn_q, attacker_turn_nxt;
    logic              battle_active_q, battle_active_nxt;
    logic              turn_owner_q, turn_owner_nxt;
    logic              key_reject_q, key_reject_nxt;

    logic              win;
    logic              key_ok;
    logic [CODE_W-1:0] enemy_code;

    assign win = bus.player_win | bus.enemy_win;

    // Free-running 8-bit Fibonacci LFSR used as the enemy's move source
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Player key legality: weapons need stock, punch and kick always allowed
    always_comb begin
        key_ok = 1'b1;
        case (bus.key_code)
            CODE_SWORD: key_ok = (bus.player_remained_sword != '0);
            CODE_BAT:   key_ok = (bus.player_remained_baseballbat != '0);
            default:    key_ok = 1'b1;
        endcase
    end

    // Enemy move: LFSR pick, with kick substituted for an exhausted weapon
    always_comb begin
        enemy_code = lfsr[1:0];
        if ((lfsr[1:0] == CODE_SWORD && bus.enemy_remained_sword == '0) ||
            (lfsr[1:0] == CODE_BAT   && bus.enemy_remained_baseballbat == '0)) begin
            enemy_code = CODE_KICK;
        end
    end

    // Next state, counter and next registered outputs
    always_comb begin
        state_nxt         = state;
        cnt_nxt           = '0;
        player_choice_nxt = player_choice_q;
        enemy_choice_nxt  = enemy_choice_q;
        player_turn_nxt   = 1'b0;
        attacker_turn_nxt = 1'b0;
        turn_owner_nxt    = turn_owner_q;
        key_reject_nxt    = 1'b0;

        if (state == IDLE) begin
            if (bus.collision_detected && !win) begin
                state_nxt = WAIT_PLAYER;
            end
        end else if (state == DONE) begin
            state_nxt = DONE;
        end else if (win) begin
            // a decided battle abandons any pending strike
            state_nxt = DONE;
        end else if (!bus.collision_detected) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                WAIT_PLAYER: begin
                    if (bus.key_valid && key_ok) begin
                        player_choice_nxt = bus.key_code;
                        player_turn_nxt   = 1'b1;
                        state_nxt         = PLAYER_STRIKE;
                    end else begin
                        key_reject_nxt = bus.key_valid;
`ifdef TURN_TIMEOUT_EN
                        // idle player forfeits the choice and throws a punch
                        if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                            player_choice_nxt = CODE_PUNCH;
                            player_turn_nxt   = 1'b1;
                            state_nxt         = PLAYER_STRIKE;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                PLAYER_STRIKE: begin
                    state_nxt = COOLDOWN_P;
                end
                COOLDOWN_P: begin
                    if (cnt == CNT_W'(COOLDOWN_CYCLES - 1)) begin
                        turn_owner_nxt = 1'b1;
                        state_nxt      = ENEMY_THINK;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ENEMY_THINK: begin
                    if (cnt == CNT_W'(THINK_CYCLES - 1)) begin
                        enemy_choice_nxt  = enemy_code;
                        attacker_turn_nxt = 1'b1;
                        state_nxt         = ENEMY_STRIKE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ENEMY_STRIKE: begin
                    state_nxt = COOLDOWN_E;
                end
                COOLDOWN_E: begin
                    if (cnt == CNT_W'(COOLDOWN_CYCLES - 1)) begin
                        turn_owner_nxt = 1'b0;
                        state_nxt      = WAIT_PLAYER;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (state_nxt == IDLE || state_nxt == DONE) begin
            turn_owner_nxt = 1'b0;
        end
        battle_active_nxt = (state_nxt != IDLE) && (state_nxt != DONE);
    end

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            player_choice_q <= CODE_PUNCH;
            enemy_choice_q  <= CODE_PUNCH;
            player_turn_q   <= 1'b0;
            attacker_turn_q <= 1'b0;
            battle_active_q <= 1'b0;
            turn_owner_q    <= 1'b0;
            key_reject_q    <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            player_choice_q <= player_choice_nxt;
            enemy_choice_q  <= enemy_choice_nxt;
            player_turn_q   <= player_turn_nxt;
            attacker_turn_q <= attacker_turn_nxt;
            battle_active_q <= battle_active_nxt;
            turn_owner_q    <= turn_owner_nxt;
            key_reject_q    <= key_reject_nxt;
        end
    end

    assign bus.player_choice = player_choice_q;
    assign bus.enemy_choice  = enemy_choice_q;
    assign bus.player_turn   = player_turn_q;
    assign bus.attacker_turn = attacker_turn_q;
    assign bus.battle_active = battle_active_q;
    assign bus.turn_owner    = turn_owner_q;
    assign bus.key_reject    = key_reject_q;

endmodule

// File: doc/battle_turn_ctrl.md
Name: battle_turn_ctrl

Overview:
Turn sequencer that drives the battle engine's attack-request interface: player_choice/player_turn and enemy_choice/attacker_turn. Accepts decoded player key strobes and generates enemy attacks from an internal LFSR "AI". Reads the engine's weapon-count and win outputs so it never requests an exhausted weapon and stops issuing turns once the battle is decided. Sits between keypad decode/collision detection and the battle engine.

Parameters:
THINK_CYCLES, 16, cycles the enemy waits in ENEMY_THINK before striking (>=1)
COOLDOWN_CYCLES, 4, cycles after each strike before the next turn (>=1), lets engine HB/counters settle
LFSR_SEED, 8'hA5, LFSR reset value, must be nonzero
TIMEOUT_CYCLES, 1000, player idle limit; used only with TURN_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
collision_detected  in  1  level; high while battle is engaged
key_valid  in  1  one-cycle strobe, player key decoded
key_code  in  2  attack code: 00 punch, 01 kick, 10 sword, 11 bat
player_remained_sword  in  5  from engine
player_remained_baseballbat  in  5  from engine
enemy_remained_sword  in  5  from engine
enemy_remained_baseballbat  in  5  from engine
player_win  in  1  from engine
enemy_win  in  1  from engine
player_choice  out  2  registered attack code to engine
player_turn  out  1  one-cycle player attack request
enemy_choice  out  2  registered attack code to engine
attacker_turn  out  1  one-cycle enemy attack request
battle_active  out  1  high in any state except IDLE and DONE
turn_owner  out  1  0 = player's turn, 1 = enemy's turn
key_reject  out  1  one-cycle pulse, key refused (weapon exhausted)

Behaviour:
- Reset values: player_choice=00, enemy_choice=00, player_turn=0, attacker_turn=0, battle_active=0, turn_owner=0, key_reject=0, lfsr=LFSR_SEED, all counters 0, state IDLE. Reset mid-battle returns to IDLE immediately; no pulse completes.
- All outputs registered.
- LFSR: 8-bit Fibonacci. Every cycle after reset: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Free-running, independent of state.
- States: IDLE, WAIT_PLAYER, PLAYER_STRIKE, COOLDOWN_P, ENEMY_THINK, ENEMY_STRIKE, COOLDOWN_E, DONE.
- IDLE: when collision_detected=1 and both win inputs are 0 -> WAIT_PLAYER. Player always moves first.
- WAIT_PLAYER (turn_owner=0): key_valid=1 with an allowed code -> player_choice<=key_code and go to PLAYER_STRIKE. Code 10 with player_remained_sword==0, or code 11 with player_remained_baseballbat==0 -> key_reject=1 for one cycle and stay in WAIT_PLAYER. Codes 00/01 are always allowed.
- PLAYER_STRIKE: player_turn=1 for exactly one cycle -> COOLDOWN_P. Latency is key_valid at cycle N -> player_turn high at N+1.
- COOLDOWN_P: count COOLDOWN_CYCLES -> ENEMY_THINK; turn_owner<=1.
- ENEMY_THINK: count THINK_CYCLES. On the final count, latch enemy_choice from lfsr[1:0], except substitute 01 (kick) when the code is 10 with enemy_remained_sword==0 or 11 with enemy_remained_baseballbat==0. Then -> ENEMY_STRIKE.
- ENEMY_STRIKE: attacker_turn=1 for one cycle -> COOLDOWN_E.
- COOLDOWN_E: count COOLDOWN_CYCLES -> WAIT_PLAYER; turn_owner<=0.
- Win priority: in any non-IDLE state, player_win|enemy_win -> DONE next cycle. No strike pulse is issued in or after the cycle a win input is sampled high. A pending strike state is abandoned.
- DONE: outputs idle, battle_active=0. Leave DONE only on reset.
- Abort: collision_detected=0 in any battle state (not DONE) -> IDLE next cycle, no pulse, counters cleared. Win takes priority over abort.
- key_valid outside WAIT_PLAYER is ignored silently (no reject, not buffered).
- player_turn and attacker_turn are never high in the same cycle.
- Counters are wide enough for max(COOLDOWN_CYCLES, THINK_CYCLES, TIMEOUT_CYCLES), and reset to 0 on every state entry.

Optional Feature:
TURN_TIMEOUT_EN:
- Defined: WAIT_PLAYER counts idle cycles. Reaching TIMEOUT_CYCLES without an accepted key forces player_choice<=00 (punch) and moves to PLAYER_STRIKE. A rejected key does not restart the count; an accepted key ends the wait.
- Undefined: WAIT_PLAYER waits indefinitely and no timeout counter is built.

Test Plan:
- Reset -> all outputs 0, and lfsr reads 8'hA5 then 8'h4A one cycle after rst_n rises.
- collision=1, key_valid with code 01 at cycle N -> player_choice=01 and player_turn=1 only at N+1. attacker_turn pulses at N+1+1+COOLDOWN_CYCLES+THINK_CYCLES (N+22 with defaults).
- player_remained_sword=0, key code 10 -> key_reject pulse, no player_turn, state stays WAIT_PLAYER. A following code 00 is accepted.
- enemy_remained_sword=0 and enemy_remained_baseballbat=0 over 64 enemy turns -> enemy_choice is never 10 or 11.
- enemy_win=1 asserted in the ENEMY_THINK cycle before the strike -> no attacker_turn, battle_active=0 next cycle, and DONE holds until rst_n.
- collision drops during COOLDOWN_P -> IDLE and no further pulses. With TURN_TIMEOUT_EN and TIMEOUT_CYCLES=10, no key -> player_turn with choice 00 eleven cycles after WAIT_PLAYER entry.
